// File: rtl/cn_minsum_serial.sv
// Serial min-sum check-node processor: accumulates min1/min2/index/sign parity per node, then streams offset-corrected replies.
// Optional build macro CN_NORM_EN scales the selected magnitude by 0.75 before the offset is applied.
module cn_minsum_serial #(
    parameter int W       = 8,
    parameter int N_C     = 12,
    parameter int DEG_MAX = 16,
    parameter int OFFSET  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_last,
    output logic [$clog2(N_C)-1:0] cn_idx,
    output logic                   frame_done,
    output logic                   deg_err
);
    localparam int MW  = W - 1;
    localparam int KW  = $clog2(DEG_MAX);
    localparam int CIW = $clog2(N_C);
    localparam logic [MW-1:0] MAXMAG  = '1;
    localparam logic [MW-1:0] OFF_MAG = MW'(OFFSET);
    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [KW-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]      idx_q, idx_d;
    logic [KW-1:0]      k_q, k_d;
    logic [KW-1:0]      last_k_q, last_k_d;
    logic [MW-1:0]      min1_q, min1_d, min2_q, min2_d;
    logic               sxor_q, sxor_d;
    logic [CIW-1:0]     cn_idx_q, cn_idx_d;
    logic               frame_done_q, frame_done_d;
    logic               deg_err_q, deg_err_d;
    logic [DEG_MAX-1:0] sbuf_q;

    logic          accept, emit_hs, in_sign, emit_sign;
    logic [W-1:0]  neg_in, emit_data;
    logic [MW-1:0] in_mag, sel_mag, norm_mag, off_mag;

    assign in_ready   = (state_q == S_ACC);
    assign out_valid  = (state_q == S_EMIT);
    assign accept     = in_valid && in_ready;
    assign emit_hs    = out_valid && out_ready;
    assign cn_idx     = cn_idx_q;
    assign frame_done = frame_done_q;
    assign deg_err    = deg_err_q;

    // Input magnitude; the most negative code has no positive twin and saturates to MAXMAG.
    always_comb begin
        in_sign = in_data[W-1];
        neg_in  = -in_data;
        if (!in_sign)
            in_mag = in_data[MW-1:0];
        else if (in_data == {1'b1, {MW{1'b0}}})
            in_mag = MAXMAG;
        else
            in_mag = neg_in[MW-1:0];
    end

    // Reply magnitude: the edge holding min1 gets min2; a degree-1 node has no other edge and replies 0.
    always_comb begin
        sel_mag = (k_q == idx_q) ? min2_q : min1_q;
        if (last_k_q == '0)
            sel_mag = '0;
`ifdef CN_NORM_EN
        norm_mag = sel_mag - (sel_mag >> 2);
`else
        norm_mag = sel_mag;
`endif
        off_mag   = (norm_mag > OFF_MAG) ? norm_mag - OFF_MAG : '0;
        emit_sign = sxor_q ^ sbuf_q[k_q];
        emit_data = emit_sign ? -{1'b0, off_mag} : {1'b0, off_mag};
    end

    assign out_data = out_valid ? emit_data : '0;
    assign out_last = out_valid && (k_q == last_k_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through this block can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        k_d          = k_q;
        last_k_d     = last_k_q;
        min1_d       = min1_q;
        min2_d       = min2_q;
        sxor_d       = sxor_q;
        cn_idx_d     = cn_idx_q;
        deg_err_d    = deg_err_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    sxor_d = sxor_q ^ in_sign;
                    if (in_mag < min1_q) begin
                        min2_d = min1_q;
                        min1_d = in_mag;
                        idx_d  = cnt_q;
                    end else if (in_mag < min2_q) begin
                        min2_d = in_mag;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (in_last || cnt_q == KW'(DEG_MAX - 1)) begin
                        state_d  = S_EMIT;
                        last_k_d = cnt_q;
                        k_d      = '0;
                        if (!in_last)
                            deg_err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (emit_hs) begin
                    k_d = k_q + 1'b1;
                    if (k_q == last_k_q) begin
                        state_d = S_ACC;
                        k_d     = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        min1_d  = MAXMAG;
                        min2_d  = MAXMAG;
                        sxor_d  = 1'b0;
                        if (cn_idx_q == CIW'(N_C - 1)) begin
                            cn_idx_d     = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            cn_idx_d = cn_idx_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_ACC;
            cnt_q        <= '0;
            idx_q        <= '0;
            k_q          <= '0;
            last_k_q     <= '0;
            min1_q       <= MAXMAG;
            min2_q       <= MAXMAG;
            sxor_q       <= 1'b0;
            cn_idx_q     <= '0;
            frame_done_q <= 1'b0;
            deg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            k_q          <= k_d;
            last_k_q     <= last_k_d;
            min1_q       <= min1_d;
            min2_q       <= min2_d;
            sxor_q       <= sxor_d;
            cn_idx_q     <= cn_idx_d;
            frame_done_q <= frame_done_d;
            deg_err_q    <= deg_err_d;
        end
    end

    // NOTE: the sign buffer is deliberately not reset; each entry is written before it is read back for the same node.
    always_ff @(posedge clk) begin
        if (accept)
            sbuf_q[cnt_q] <= in_sign;
    end
endmodule

// File: tb/tb_cn_minsum_serial.sv
// Directed bench for cn_minsum_serial: instance A (OFFSET=1, DEG_MAX=16) and instance B (OFFSET=0, DEG_MAX=4), both N_C=3.
// Build with CN_NORM_EN defined to run the normalisation vector instead of the default suite.
module tb_cn_minsum_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic in_valid, in_last, out_ready;
    logic [W-1:0] in_data;

    logic iv_a, ir_a, ov_a, or_a, ol_a, fd_a, de_a;
    logic iv_b, ir_b, ov_b, or_b, ol_b, fd_b, de_b;
    logic [W-1:0] od_a, od_b;
    logic [1:0] ci_a, ci_b;

    logic in_ready, out_valid_s, out_last_s, frame_done_s, deg_err_s;
    logic [W-1:0] out_data_s;
    logic [1:0] cn_idx_s;

    int n_tests = 0;
    int n_fail  = 0;
    int vin[$];
    int vexp[$];

    always #5 clk = ~clk;

    assign iv_a = !sel && in_valid;
    assign iv_b =  sel && in_valid;
    assign or_a = !sel && out_ready;
    assign or_b =  sel && out_ready;
    assign in_ready     = sel ? ir_b : ir_a;
    assign out_valid_s  = sel ? ov_b : ov_a;
    assign out_data_s   = sel ? od_b : od_a;
    assign out_last_s   = sel ? ol_b : ol_a;
    assign cn_idx_s     = sel ? ci_b : ci_a;
    assign frame_done_s = sel ? fd_b : fd_a;
    assign deg_err_s    = sel ? de_b : de_a;

    cn_minsum_serial #(.W(W), .N_C(3), .DEG_MAX(16), .OFFSET(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(in_data), .in_last(in_last),
        .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_last(ol_a),
        .cn_idx(ci_a), .frame_done(fd_a), .deg_err(de_a)
    );

    cn_minsum_serial #(.W(W), .N_C(3), .DEG_MAX(4), .OFFSET(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(in_data), .in_last(in_last),
        .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_last(ol_b),
        .cn_idx(ci_b), .frame_done(fd_b), .deg_err(de_b)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Streams vin into the selected instance; with_last=0 leaves in_last low to force a degree overflow.
    task automatic send_node(input string tag, input bit with_last);
        for (int i = 0; i < vin.size(); i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = vin[i][W-1:0];
            in_last  = with_last && (i == vin.size() - 1);
            @(negedge clk);
            while (!in_ready && t < 50) begin
                t++;
                @(negedge clk);
            end
            check($sformatf("%s.in_ready[%0d]", tag, i), in_ready, 1);
            check($sformatf("%s.ovalid_acc[%0d]", tag, i), out_valid_s, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, ".first_out_latency"}, out_valid_s, 1);
    endtask

    // Collects vexp from the selected instance; stall_at >= 0 holds out_ready low 3 cycles before that beat.
    task automatic recv_node(input string tag, input int stall_at);
        for (int i = 0; i < vexp.size(); i++) begin
            int t = 0;
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check($sformatf("%s.stall_valid[%0d]", tag, c), out_valid_s, 1);
                    check($sformatf("%s.stall_data[%0d]", tag, c), $signed(out_data_s), vexp[i]);
                    check($sformatf("%s.stall_last[%0d]", tag, c), out_last_s, (i == vexp.size() - 1) ? 1 : 0);
                    check($sformatf("%s.stall_in_ready[%0d]", tag, c), in_ready, 0);
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            while (!out_valid_s && t < 50) begin
                t++;
                @(negedge clk);
            end
            check($sformatf("%s.valid[%0d]", tag, i), out_valid_s, 1);
            check($sformatf("%s.data[%0d]", tag, i), $signed(out_data_s), vexp[i]);
            check($sformatf("%s.last[%0d]", tag, i), out_last_s, (i == vexp.size() - 1) ? 1 : 0);
            check($sformatf("%s.in_ready_emit[%0d]", tag, i), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst%0d.out_valid", s), out_valid_s, 0);
            check($sformatf("rst%0d.out_data", s), out_data_s, 0);
            check($sformatf("rst%0d.out_last", s), out_last_s, 0);
            check($sformatf("rst%0d.frame_done", s), frame_done_s, 0);
            check($sformatf("rst%0d.deg_err", s), deg_err_s, 0);
            check($sformatf("rst%0d.cn_idx", s), cn_idx_s, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        sel = 1'b1;

`ifdef CN_NORM_EN
        vin = '{8, 12}; vexp = '{9, 6};
        send_node("norm", 1'b1);
        recv_node("norm", -1);
`else
        // Instance B, OFFSET=0: saturation of the most negative code.
        check("b.cn_idx0", cn_idx_s, 0);
        vin = '{-128, 10}; vexp = '{10, -127};
        send_node("sat", 1'b1);
        recv_node("sat", -1);
        check("sat.frame_done", frame_done_s, 0);

        // Equal magnitudes: min1 stays on the earlier edge.
        check("b.cn_idx1", cn_idx_s, 1);
        vin = '{4, -4, 9}; vexp = '{-4, 4, -4};
        send_node("ties", 1'b1);
        recv_node("ties", -1);
        check("ties.deg_err", deg_err_s, 0);

        // DEG_MAX=4 with no in_last: emit is forced after the 4th edge.
        check("b.cn_idx2", cn_idx_s, 2);
        vin = '{3, -5, 6, 2}; vexp = '{-2, 2, -2, -3};
        send_node("forced", 1'b0);
        check("forced.deg_err", deg_err_s, 1);
        recv_node("forced", -1);
        check("forced.frame_done", frame_done_s, 1);
        check("forced.cn_idx_wrap", cn_idx_s, 0);
        @(posedge clk); #1;
        check("forced.frame_done_pulse", frame_done_s, 0);

        vin = '{8, 12}; vexp = '{12, 8};
        send_node("plain", 1'b1);
        recv_node("plain", -1);
        check("plain.deg_err_sticky", deg_err_s, 1);

        // Degree-1 node replies 0 regardless of the input.
        vin = '{-7}; vexp = '{0};
        send_node("deg1", 1'b1);
        recv_node("deg1", -1);

        // Instance A, OFFSET=1: one frame of three degree-3 nodes.
        sel = 1'b0;
        #1;
        check("a.cn_idx0", cn_idx_s, 0);
        vin = '{0, 6, -6}; vexp = '{-5, 0, 0};
        send_node("zero", 1'b1);
        recv_node("zero", -1);
        check("zero.frame_done", frame_done_s, 0);

        check("a.cn_idx1", cn_idx_s, 1);
        vin = '{5, -3, 7}; vexp = '{-2, 4, -2};
        send_node("bp", 1'b1);
        recv_node("bp", 2);
        check("bp.frame_done", frame_done_s, 0);

        check("a.cn_idx2", cn_idx_s, 2);
        vin = '{2, -9, 3}; vexp = '{-2, 1, -1};
        send_node("n2", 1'b1);
        recv_node("n2", -1);
        check("n2.frame_done", frame_done_s, 1);
        check("n2.cn_idx_wrap", cn_idx_s, 0);
        @(posedge clk); #1;
        check("n2.frame_done_pulse", frame_done_s, 0);
        check("a.deg_err", deg_err_s, 0);

        vin = '{5, -3, 7, -2}; vexp = '{1, -1, 1, -2};
        send_node("basic", 1'b1);
        recv_node("basic", -1);

        // Reset while emitting node 1 after one reply has been taken.
        check("mid.cn_idx", cn_idx_s, 1);
        vin = '{5, -3, 7};
        send_node("mid", 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("mid.data0", $signed(out_data_s), -2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("mid.rst_out_valid", out_valid_s, 0);
        check("mid.rst_out_data", out_data_s, 0);
        check("mid.rst_cn_idx", cn_idx_s, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("post.in_ready", in_ready, 1);
        vin = '{0, 6, -6}; vexp = '{-5, 0, 0};
        send_node("post", 1'b1);
        recv_node("post", -1);
        check("post.cn_idx", cn_idx_s, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
